// File: rtl/alt_mem_ddrx_ecc_enc_arbiter_if.sv
// Handshake bundle shared by the wr/rmw requesters, the ECC encoder ports and the output queue.
interface alt_mem_ddrx_ecc_enc_arbiter_if #(
    parameter int DATA_W = 40,
    parameter int CODE_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic [CODE_W-1:0] wr_ecc_code;
    logic              wr_ecc_code_overwrite;

    logic              rmw_valid;
    logic              rmw_ready;
    logic [DATA_W-1:0] rmw_data;
    logic [CODE_W-1:0] rmw_ecc_code;
    logic              rmw_ecc_code_overwrite;

    logic [DATA_W-1:0] enc_input_data;
    logic [CODE_W-1:0] enc_input_ecc_code;
    logic              enc_input_ecc_code_overwrite;
    logic [DATA_W-1:0] enc_output_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_src;

    modport slave (
        input  wr_valid, wr_data, wr_ecc_code, wr_ecc_code_overwrite,
        output wr_ready,
        input  rmw_valid, rmw_data, rmw_ecc_code, rmw_ecc_code_overwrite,
        output rmw_ready,
        output enc_input_data, enc_input_ecc_code, enc_input_ecc_code_overwrite,
        input  enc_output_data,
        output out_valid, out_data, out_src,
        input  out_ready
    );

    modport master (
        output wr_valid, wr_data, wr_ecc_code, wr_ecc_code_overwrite,
        input  wr_ready,
        output rmw_valid, rmw_data, rmw_ecc_code, rmw_ecc_code_overwrite,
        input  rmw_ready,
        input  enc_input_data, enc_input_ecc_code, enc_input_ecc_code_overwrite,
        output enc_output_data,
        input  out_valid, out_data, out_src,
        output out_ready
    );
endinterface

// File: rtl/alt_mem_ddrx_ecc_enc_arbiter.sv
// Shares one ECC encoder between the host write path and the RMW merge path; encoded
// words are queued in grant order with their source tag, credit-limited so none is dropped.
module alt_mem_ddrx_ecc_enc_arbiter #(
    parameter int CFG_DATA_WIDTH            = 40,
    parameter int CFG_ECC_CODE_WIDTH        = 8,
    parameter int CFG_ENC_LATENCY           = 1,
    parameter int CFG_FIFO_DEPTH            = 4,
    parameter int CFG_FIFO_ADDR_WIDTH       = 2,
    parameter int CFG_STARVE_LIMIT          = 4,
    parameter int CFG_PORT_WIDTH_ENABLE_ECC = 1
) (
    input  logic                                 ctl_clk,
    input  logic                                 ctl_reset_n,
    input  logic [CFG_PORT_WIDTH_ENABLE_ECC-1:0] cfg_enable_ecc,
    alt_mem_ddrx_ecc_enc_arbiter_if.slave        bus,
    output logic                                 busy
);
    localparam int LAT  = CFG_ENC_LATENCY;
    localparam int CNTW = CFG_FIFO_ADDR_WIDTH + 1;
    localparam int CRW  = CFG_FIFO_ADDR_WIDTH + 2;

    logic [3:0]                     starve_cnt;
    logic                           starve_hit;
    logic                           can_grant;
    logic                           gnt_wr;
    logic                           gnt_rmw;
    logic                           grant;
    logic                           ecc_en;
    logic                           push;
    logic                           push_src;
    logic                           pop;
    logic [CFG_FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [CFG_FIFO_ADDR_WIDTH-1:0] rd_ptr;
    logic [CNTW-1:0]                fifo_count;
    logic [CNTW-1:0]                fifo_count_nxt;
    logic [CRW-1:0]                 pipe_cnt;
    logic [CRW-1:0]                 credit_used;
    logic                           pipe_busy_nxt;

    logic [CFG_DATA_WIDTH-1:0]      fifo_data [CFG_FIFO_DEPTH];
    logic [CFG_FIFO_DEPTH-1:0]      fifo_src;

    // Credit covers beats already inside the encoder, so a stalled FIFO can never overflow.
    // Gating with the reset keeps both readys low for the whole reset window.
    assign credit_used = pipe_cnt + CRW'(fifo_count);
    assign can_grant   = ctl_reset_n && (credit_used < CRW'(CFG_FIFO_DEPTH));
    assign starve_hit  = bus.wr_valid && (starve_cnt == 4'(CFG_STARVE_LIMIT));
    assign gnt_rmw     = can_grant && bus.rmw_valid && !starve_hit;
    assign gnt_wr      = can_grant && bus.wr_valid && !gnt_rmw;
    assign grant       = gnt_wr || gnt_rmw;
    assign ecc_en      = |cfg_enable_ecc;

    assign bus.wr_ready  = gnt_wr;
    assign bus.rmw_ready = gnt_rmw;

    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            starve_cnt <= '0;
        end else if (!bus.wr_valid || gnt_wr) begin
            starve_cnt <= '0;
        end else if (gnt_rmw && (starve_cnt < 4'(CFG_STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_comb begin
        bus.enc_input_data               = '0;
        bus.enc_input_ecc_code           = '0;
        bus.enc_input_ecc_code_overwrite = 1'b0;
        if (gnt_rmw) begin
            bus.enc_input_data               = bus.rmw_data;
            bus.enc_input_ecc_code           = bus.rmw_ecc_code;
            bus.enc_input_ecc_code_overwrite = bus.rmw_ecc_code_overwrite && ecc_en;
        end else if (gnt_wr) begin
            bus.enc_input_data               = bus.wr_data;
            bus.enc_input_ecc_code           = bus.wr_ecc_code;
            bus.enc_input_ecc_code_overwrite = bus.wr_ecc_code_overwrite && ecc_en;
        end
    end

    // Tag pipe mirrors the encoder latency; its exit strobes the encoder output into the FIFO.
    generate
        if (LAT == 0) begin : g_nopipe
            assign push          = grant;
            assign push_src      = gnt_rmw;
            assign pipe_cnt      = '0;
            assign pipe_busy_nxt = 1'b0;
        end else begin : g_pipe
            logic [LAT-1:0] vld_pipe;
            logic [LAT-1:0] src_pipe;

            always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
                if (!ctl_reset_n) begin
                    vld_pipe <= '0;
                    src_pipe <= '0;
                end else begin
                    vld_pipe[0] <= grant;
                    src_pipe[0] <= gnt_rmw;
                    for (int i = 1; i < LAT; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                        src_pipe[i] <= src_pipe[i-1];
                    end
                end
            end

            always_comb begin
                pipe_cnt      = '0;
                pipe_busy_nxt = grant;
                for (int i = 0; i < LAT; i++) begin
                    pipe_cnt = pipe_cnt + CRW'(vld_pipe[i]);
                    if (i < LAT - 1) pipe_busy_nxt = pipe_busy_nxt || vld_pipe[i];
                end
            end

            assign push     = vld_pipe[LAT-1];
            assign push_src = src_pipe[LAT-1];
        end
    endgenerate

    assign pop            = (fifo_count != '0) && bus.out_ready;
    assign fifo_count_nxt = fifo_count + CNTW'(push) - CNTW'(pop);

    always_ff @(posedge ctl_clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.enc_output_data;
            fifo_src[wr_ptr]  <= push_src;
        end
    end

    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            busy       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count_nxt;
            busy       <= pipe_busy_nxt || (fifo_count_nxt != '0);
        end
    end

    // Head is masked when empty so storage left over from before a reset is never visible.
    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
    assign bus.out_src   = bus.out_valid && fifo_src[rd_ptr];
endmodule

// File: tb/tb_alt_mem_ddrx_ecc_enc_arbiter.sv
// Directed bench: latency-1 instance for arbitration/credit/reset, latency-0 instance for streaming.
module tb_alt_mem_ddrx_ecc_enc_arbiter;
    localparam int DW = 40;
    localparam int CW = 8;

    logic          ctl_clk = 1'b0;
    logic          ctl_reset_n;
    logic [0:0]    cfg_enable_ecc;
    logic          busy;
    logic          busy0;
    logic [DW-1:0] enc_q;
    int            total = 0;
    int            bad = 0;

    alt_mem_ddrx_ecc_enc_arbiter_if #(.DATA_W(DW), .CODE_W(CW)) bus ();
    alt_mem_ddrx_ecc_enc_arbiter_if #(.DATA_W(DW), .CODE_W(CW)) bus0 ();

    alt_mem_ddrx_ecc_enc_arbiter #(.CFG_ENC_LATENCY(1)) dut (
        .ctl_clk(ctl_clk), .ctl_reset_n(ctl_reset_n), .cfg_enable_ecc(cfg_enable_ecc),
        .bus(bus), .busy(busy));

    alt_mem_ddrx_ecc_enc_arbiter #(.CFG_ENC_LATENCY(0)) dut0 (
        .ctl_clk(ctl_clk), .ctl_reset_n(ctl_reset_n), .cfg_enable_ecc(cfg_enable_ecc),
        .bus(bus0), .busy(busy0));

    always #5 ctl_clk = ~ctl_clk;

    // Stand-in encoder: flips the top byte so output is distinguishable from input.
    function automatic logic [DW-1:0] enc_f(input logic [DW-1:0] d);
        return d ^ 40'h5A_0000_0000;
    endfunction

    always @(posedge ctl_clk) enc_q <= enc_f(bus.enc_input_data);
    assign bus.enc_output_data  = enc_q;
    assign bus0.enc_output_data = enc_f(bus0.enc_input_data);

    task automatic tick();
        @(negedge ctl_clk);
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 0; bus.wr_data = '0; bus.wr_ecc_code = '0; bus.wr_ecc_code_overwrite = 0;
        bus.rmw_valid = 0; bus.rmw_data = '0; bus.rmw_ecc_code = '0; bus.rmw_ecc_code_overwrite = 0;
        bus0.wr_valid = 0; bus0.wr_data = '0; bus0.wr_ecc_code = '0; bus0.wr_ecc_code_overwrite = 0;
        bus0.rmw_valid = 0; bus0.rmw_data = '0; bus0.rmw_ecc_code = '0; bus0.rmw_ecc_code_overwrite = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        bus.out_ready = 1; bus0.out_ready = 1;
        while ((busy || busy0) && n < 30) begin tick(); n++; end
        total++;
        if (busy || busy0) begin bad++; $display("FAIL %s_drain: still busy after %0d cycles", name, n); end
    endtask

    task automatic test_reset();
        ctl_reset_n = 0; cfg_enable_ecc = 1; idle_inputs();
        bus.out_ready = 1; bus0.out_ready = 1;
        bus.wr_valid = 1; bus.rmw_valid = 1;
        tick(); tick(); #1;
        total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%b exp=0", bus.wr_ready); end
        total++; if (bus.rmw_ready !== 1'b0) begin bad++; $display("FAIL rst_rmw_ready got=%b exp=0", bus.rmw_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (bus.out_data !== '0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
        total++; if (bus.out_src !== 1'b0) begin bad++; $display("FAIL rst_out_src got=%b exp=0", bus.out_src); end
        tick(); idle_inputs(); bus.out_ready = 0; ctl_reset_n = 1;
    endtask

    task automatic test_single();
        tick();
        bus.wr_valid = 1; bus.wr_data = 40'h12_3456_789A; #1;
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL single_wr_ready got=%b exp=1", bus.wr_ready); end
        total++; if (bus.enc_input_data !== 40'h12_3456_789A) begin bad++; $display("FAIL single_enc_in got=%h exp=123456789a", bus.enc_input_data); end
        tick(); bus.wr_valid = 0; #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_out_valid_c1 got=%b exp=0", bus.out_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_c1 got=%b exp=1", busy); end
        total++; if (bus.enc_input_data !== '0) begin bad++; $display("FAIL single_enc_idle got=%h exp=0", bus.enc_input_data); end
        tick(); #1;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid_c2 got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_data !== 40'h48_3456_789A) begin bad++; $display("FAIL single_out_data got=%h exp=483456789a", bus.out_data); end
        total++; if (bus.out_src !== 1'b0) begin bad++; $display("FAIL single_out_src got=%b exp=0", bus.out_src); end
        bus.out_ready = 1;
        tick(); #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_out_valid_c3 got=%b exp=0", bus.out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_c3 got=%b exp=0", busy); end
    endtask

    task automatic test_starve();
        bus.out_ready = 1;
        bus.wr_data = 40'h00_0000_0A0A; bus.rmw_data = 40'h00_0000_0B0B;
        for (int k = 0; k < 15; k++) begin
            tick();
            bus.wr_valid = 1; bus.rmw_valid = 1; #1;
            total++;
            if (bus.wr_ready !== (k % 5 == 4) || bus.rmw_ready !== (k % 5 != 4)) begin
                bad++; $display("FAIL starve_grant k=%0d got wr=%b rmw=%b exp wr=%b", k, bus.wr_ready, bus.rmw_ready, k % 5 == 4);
            end
            total++;
            if (dut.starve_cnt > 4) begin bad++; $display("FAIL starve_cnt_max k=%0d got=%0d exp<=4", k, dut.starve_cnt); end
            if (k >= 2) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_src !== ((k - 2) % 5 != 4)) begin
                    bad++; $display("FAIL starve_order k=%0d got v=%b src=%b exp src=%b", k, bus.out_valid, bus.out_src, (k - 2) % 5 != 4);
                end
            end
        end
        tick(); idle_inputs();
        wait_idle("starve");
    endtask

    task automatic test_backpressure();
        logic          exp_src [4];
        logic [DW-1:0] exp_dat [4];
        int            got = 0;
        exp_src = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_dat = '{enc_f(40'h00_0000_00C2), enc_f(40'h00_0000_00C2), enc_f(40'h00_0000_00C2), enc_f(40'h00_0000_00D1)};
        tick(); bus.out_ready = 0;
        bus.wr_data = 40'h00_0000_00D1; bus.rmw_data = 40'h00_0000_00C2;
        for (int k = 0; k < 8; k++) begin
            bus.wr_valid = 1; bus.rmw_valid = 1; #1;
            total++;
            if ((bus.wr_ready || bus.rmw_ready) !== (k < 4)) begin
                bad++; $display("FAIL bp_grant k=%0d got wr=%b rmw=%b exp any=%b", k, bus.wr_ready, bus.rmw_ready, k < 4);
            end
            total++;
            if (dut.push && dut.fifo_count == 3'd4 && !dut.pop) begin bad++; $display("FAIL bp_push_full k=%0d got push into full FIFO", k); end
            tick();
        end
        bus.out_ready = 1; #1;
        total++; if (bus.wr_ready !== 1'b0 || bus.rmw_ready !== 1'b0) begin bad++; $display("FAIL bp_pop_cycle got wr=%b rmw=%b exp 0", bus.wr_ready, bus.rmw_ready); end
        total++; if (bus.out_src !== 1'b1 || bus.out_data !== enc_f(40'h00_0000_00C2)) begin bad++; $display("FAIL bp_pop_head got src=%b data=%h", bus.out_src, bus.out_data); end
        tick(); bus.out_ready = 0; #1;
        total++; if (bus.wr_ready !== 1'b1 || bus.rmw_ready !== 1'b0) begin bad++; $display("FAIL bp_regrant got wr=%b rmw=%b exp wr=1 rmw=0", bus.wr_ready, bus.rmw_ready); end
        tick(); #1;
        total++; if (bus.wr_ready !== 1'b0 || bus.rmw_ready !== 1'b0) begin bad++; $display("FAIL bp_refull got wr=%b rmw=%b exp 0", bus.wr_ready, bus.rmw_ready); end
        tick(); idle_inputs(); bus.out_ready = 1;
        for (int n = 0; n < 12 && got < 4; n++) begin
            #1;
            if (bus.out_valid) begin
                total++;
                if (bus.out_src !== exp_src[got] || bus.out_data !== exp_dat[got]) begin
                    bad++; $display("FAIL bp_drain_%0d got src=%b data=%h exp src=%b data=%h", got, bus.out_src, bus.out_data, exp_src[got], exp_dat[got]);
                end
                got++;
            end
            tick();
        end
        total++; if (got != 4) begin bad++; $display("FAIL bp_drain_count got=%0d exp=4", got); end
        wait_idle("bp");
    endtask

    task automatic test_overwrite();
        tick(); cfg_enable_ecc = 1; bus.out_ready = 1;
        bus.rmw_valid = 1; bus.rmw_data = 40'h00_0000_1111; bus.rmw_ecc_code = 8'hA5; bus.rmw_ecc_code_overwrite = 1; #1;
        total++; if (bus.enc_input_ecc_code_overwrite !== 1'b1 || bus.enc_input_ecc_code !== 8'hA5) begin bad++; $display("FAIL ow_rmw_en got ow=%b code=%h exp ow=1 code=a5", bus.enc_input_ecc_code_overwrite, bus.enc_input_ecc_code); end
        tick(); bus.rmw_valid = 0;
        bus.wr_valid = 1; bus.wr_ecc_code = 8'h3C; bus.wr_ecc_code_overwrite = 1; #1;
        total++; if (bus.enc_input_ecc_code_overwrite !== 1'b1 || bus.enc_input_ecc_code !== 8'h3C) begin bad++; $display("FAIL ow_wr_en got ow=%b code=%h exp ow=1 code=3c", bus.enc_input_ecc_code_overwrite, bus.enc_input_ecc_code); end
        tick(); bus.wr_valid = 0; cfg_enable_ecc = 0; bus.rmw_valid = 1; #1;
        total++; if (bus.rmw_ready !== 1'b1 || bus.enc_input_ecc_code_overwrite !== 1'b0) begin bad++; $display("FAIL ow_rmw_dis got rdy=%b ow=%b exp rdy=1 ow=0", bus.rmw_ready, bus.enc_input_ecc_code_overwrite); end
        tick(); idle_inputs(); cfg_enable_ecc = 1;
        wait_idle("ow");
    endtask

    task automatic test_reset_flush();
        tick(); bus.out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            bus.rmw_valid = 1; bus.rmw_data = 40'hBB_0000_0000 + 40'(k);
            tick();
        end
        bus.rmw_valid = 0; #1;
        total++; if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL flush_pre got v=%b busy=%b exp 1 1", bus.out_valid, busy); end
        bus.wr_valid = 1; bus.rmw_valid = 1; #1;
        ctl_reset_n = 0; #1;
        total++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_out got v=%b busy=%b exp 0 0", bus.out_valid, busy); end
        total++; if (bus.wr_ready !== 1'b0 || bus.rmw_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got wr=%b rmw=%b exp 0 0", bus.wr_ready, bus.rmw_ready); end
        tick(); idle_inputs(); tick();
        ctl_reset_n = 1; bus.out_ready = 1;
        bus.wr_valid = 1; bus.wr_data = 40'h01_0203_0405; #1;
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL flush_new_ready got=%b exp=1", bus.wr_ready); end
        tick(); bus.wr_valid = 0; #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale got v=%b data=%h exp v=0", bus.out_valid, bus.out_data); end
        tick(); #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 40'h5B_0203_0405 || bus.out_src !== 1'b0) begin bad++; $display("FAIL flush_new_out got v=%b data=%h src=%b exp 1 5b02030405 0", bus.out_valid, bus.out_data, bus.out_src); end
        tick(); #1;
        total++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_after got v=%b busy=%b exp 0 0", bus.out_valid, busy); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d [8];
        for (int k = 0; k < 8; k++) d[k] = {8'(8'h10 + k), 32'(32'hCAFE_0000 + k)};
        tick(); bus0.out_ready = 1;
        for (int k = 0; k <= 9; k++) begin
            bus0.wr_valid = (k < 8);
            bus0.wr_data  = (k < 8) ? d[k] : '0;
            #1;
            if (k < 8) begin
                total++; if (bus0.wr_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, bus0.wr_ready); end
            end
            if (k == 0 || k == 9) begin
                total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty k=%0d got v=%b exp 0", k, bus0.out_valid); end
            end else begin
                total++;
                if (bus0.out_valid !== 1'b1 || bus0.out_data !== enc_f(d[k-1]) || bus0.out_src !== 1'b0) begin
                    bad++; $display("FAIL b2b_out k=%0d got v=%b data=%h exp data=%h", k, bus0.out_valid, bus0.out_data, enc_f(d[k-1]));
                end
            end
            tick();
        end
        idle_inputs();
        wait_idle("b2b");
    endtask

    initial begin
        test_reset();
        test_single();
        test_starve();
        test_backpressure();
        test_overwrite();
        test_reset_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
